// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Package     : keypad_pkg
// Description : Shared keypad key codes, key classification helper and the
//               PIN-entry FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Edit/command key codes delivered by the keypad scanner
  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_BACKSPACE = 4'hE;
  localparam logic [3:0] KEY_ENTER     = 4'hF;

  typedef enum logic [1:0] {
    PE_IDLE    = 2'd0,
    PE_COLLECT = 2'd1,
    PE_PRESENT = 2'd2
  } pin_state_t;

  // Key codes 0x0..0x9 are numeric digits
  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inactivity_timer.sv
`default_nettype none
// ============================================================================
// Module      : inactivity_timer
// Description : Counts consecutive idle cycles while running; flags expiry on
//               the cycle that would complete CYCLES idle cycles. A clear in
//               that same cycle suppresses the expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module inactivity_timer #(
  parameter int CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int               CNT_W  = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Idle-cycle counter: zeroed by clear or when not running, saturates at the last count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || !run) begin
      r_count <= '0;
    end else if (r_count != c_last) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry is combinational so the owning FSM can act on the very edge that completes the count
  assign expire = run && !clear && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/pin_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : pin_entry_controller
// Description : Assembles keypad digit events into a PIN with backspace/clear
//               editing and inactivity timeout, then offers the finished PIN
//               to the lock FSM over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_entry_controller
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS     = 8,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [3:0]                        key_value,
  input  logic                              key_valid,
  output logic [4*MAX_DIGITS-1:0]           pin_digits,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   pin_len,
  output logic                              pin_valid,
  input  logic                              pin_ready,
  output logic                              entry_active,
  output logic                              key_ack,
  output logic                              entry_error,
  output logic                              entry_timeout
);

  localparam int               BUF_W = 4 * MAX_DIGITS;
  localparam int               LEN_W = $clog2(MAX_DIGITS + 1);
  localparam logic [LEN_W-1:0] c_max = LEN_W'(MAX_DIGITS);
  localparam logic [LEN_W-1:0] c_min = LEN_W'(MIN_DIGITS);
  localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

  pin_state_t       r_state;
  logic [BUF_W-1:0] r_digits;
  logic [LEN_W-1:0] r_len;
  logic             r_valid;
  logic             r_active;
  logic             r_ack;
  logic             r_err;
  logic             r_to;

  logic             w_timer_clear;
  logic             w_timer_run;
  logic             w_expire;

  // Timer only advances while collecting with entry enabled; any key restarts the idle window
  assign w_timer_run   = (r_state == PE_COLLECT) && enable;
  assign w_timer_clear = key_valid || !w_timer_run;

  inactivity_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_timer_clear),
    .run    (w_timer_run),
    .expire (w_expire)
  );

  // Entry FSM with nibble shift buffer; every output is registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= PE_IDLE;
      r_digits <= '1;
      r_len    <= '0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_to  <= 1'b0;
      case (r_state)
        PE_IDLE: begin
          if (enable && key_valid && is_digit(key_value)) begin
            r_digits <= {{(MAX_DIGITS-1){4'hF}}, key_value};
            r_len    <= c_one;
            r_ack    <= 1'b1;
            r_active <= 1'b1;
            r_state  <= PE_COLLECT;
          end
        end

        PE_COLLECT: begin
          if (!enable) begin
            r_digits <= '1;
            r_len    <= '0;
            r_active <= 1'b0;
            r_state  <= PE_IDLE;
          end else if (key_valid) begin
            if (is_digit(key_value)) begin
              if (r_len < c_max) begin
                r_digits <= {r_digits[BUF_W-5:0], key_value};
                r_len    <= r_len + c_one;
                r_ack    <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end else if (key_value == KEY_BACKSPACE) begin
              r_ack <= 1'b1;
              if (r_len <= c_one) begin
                // Removing the last digit ends the entry
                r_digits <= '1;
                r_len    <= '0;
                r_active <= 1'b0;
                r_state  <= PE_IDLE;
              end else begin
                r_digits <= {4'hF, r_digits[BUF_W-1:4]};
                r_len    <= r_len - c_one;
              end
            end else if (key_value == KEY_CLEAR) begin
              r_digits <= '1;
              r_len    <= '0;
              r_ack    <= 1'b1;
              r_active <= 1'b0;
              r_state  <= PE_IDLE;
            end else if (key_value == KEY_ENTER) begin
              r_active <= 1'b0;
              if (r_len >= c_min) begin
                r_valid <= 1'b1;
                r_state <= PE_PRESENT;
              end else begin
                r_digits <= '1;
                r_len    <= '0;
                r_err    <= 1'b1;
                r_state  <= PE_IDLE;
              end
            end
            // 0xA/0xB/0xD only restart the inactivity window
          end else if (w_expire) begin
            r_digits <= '1;
            r_len    <= '0;
            r_to     <= 1'b1;
            r_active <= 1'b0;
            r_state  <= PE_IDLE;
          end
        end

        PE_PRESENT: begin
          // PIN is frozen here; keys and enable are ignored until the consumer takes it
          if (pin_ready) begin
            r_valid  <= 1'b0;
            r_digits <= '1;
            r_len    <= '0;
            r_state  <= PE_IDLE;
          end
        end

        default: begin
          r_digits <= '1;
          r_len    <= '0;
          r_valid  <= 1'b0;
          r_active <= 1'b0;
          r_state  <= PE_IDLE;
        end
      endcase
    end
  end

  assign pin_digits    = r_digits;
  assign pin_len       = r_len;
  assign pin_valid     = r_valid;
  assign entry_active  = r_active;
  assign key_ack       = r_ack;
  assign entry_error   = r_err;
  assign entry_timeout = r_to;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pin_entry_controller
// Description : Directed self-checking bench for pin_entry_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_entry_controller;

  localparam int MAXD = 8;
  localparam int MIND = 4;
  localparam int TOC  = 20;
  localparam int LW   = $clog2(MAXD + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic [3:0]        key_value = 4'h0;
  logic              key_valid = 1'b0;
  logic [4*MAXD-1:0] pin_digits;
  logic [LW-1:0]     pin_len;
  logic              pin_valid;
  logic              pin_ready = 1'b0;
  logic              entry_active;
  logic              key_ack;
  logic              entry_error;
  logic              entry_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  // Pulse counters, only ever written by the monitor below
  int n_ack = 0;
  int n_err = 0;
  int n_to  = 0;
  int n_pv  = 0;

  int b_ack, b_err, b_to, b_pv;

  pin_entry_controller #(
    .MAX_DIGITS     (MAXD),
    .MIN_DIGITS     (MIND),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .key_value     (key_value),
    .key_valid     (key_valid),
    .pin_digits    (pin_digits),
    .pin_len       (pin_len),
    .pin_valid     (pin_valid),
    .pin_ready     (pin_ready),
    .entry_active  (entry_active),
    .key_ack       (key_ack),
    .entry_error   (entry_error),
    .entry_timeout (entry_timeout)
  );

  always #5 clk = ~clk;

  // Count one-cycle pulses and pin_valid cycles mid-period
  always @(negedge clk) begin
    if (!reset) begin
      n_ack <= n_ack + int'(key_ack);
      n_err <= n_err + int'(entry_error);
      n_to  <= n_to + int'(entry_timeout);
      n_pv  <= n_pv + int'(pin_valid);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge (inputs change and outputs are read here)
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_value = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic snap();
    b_ack = n_ack;
    b_err = n_err;
    b_to  = n_to;
    b_pv  = n_pv;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_digits", 64'(pin_digits), 64'hFFFF_FFFF);
    chk("rst_len", 64'(pin_len), 64'd0);
    chk("rst_valid", 64'(pin_valid), 64'd0);
    chk("rst_active", 64'(entry_active), 64'd0);

    // ---------------- 1: 1,2,3,4,ENTER with ready already high ----------------
    pin_ready = 1'b1;
    snap();
    press(4'h1);
    chk("t1_active", 64'(entry_active), 64'd1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    chk("t1_len4", 64'(pin_len), 64'd4);
    press(4'hF);
    chk("t1_valid", 64'(pin_valid), 64'd1);
    chk("t1_digits", 64'(pin_digits), 64'hFFFF_1234);
    chk("t1_len", 64'(pin_len), 64'd4);
    tick();
    chk("t1_valid_drop", 64'(pin_valid), 64'd0);
    chk("t1_cleared", 64'(pin_digits), 64'hFFFF_FFFF);
    chk("t1_pv_cycles", 64'(n_pv - b_pv), 64'd1);
    pin_ready = 1'b0;

    // ---------------- 2: editing with backspace ----------------
    snap();
    press(4'h5);
    press(4'h6);
    press(4'h7);
    press(4'hE);
    chk("t2_bs_digits", 64'(pin_digits), 64'hFFFF_FF56);
    press(4'h8);
    press(4'h9);
    press(4'hF);
    chk("t2_valid", 64'(pin_valid), 64'd1);
    chk("t2_digits", 64'(pin_digits), 64'hFFFF_5689);
    chk("t2_len", 64'(pin_len), 64'd4);
    chk("t2_acks", 64'(n_ack - b_ack), 64'd6);
    pin_ready = 1'b1;
    tick();
    pin_ready = 1'b0;
    chk("t2_done", 64'(pin_valid), 64'd0);

    // ---------------- 3: short PIN on ENTER ----------------
    snap();
    press(4'h1);
    press(4'h2);
    press(4'hF);
    tick();
    chk("t3_err", 64'(n_err - b_err), 64'd1);
    chk("t3_no_valid", 64'(n_pv - b_pv), 64'd0);
    chk("t3_len", 64'(pin_len), 64'd0);
    chk("t3_idle", 64'(entry_active), 64'd0);

    // ---------------- 4: overflow digit ----------------
    snap();
    for (int i = 1; i <= 9; i++) press(4'(i));
    chk("t4_err", 64'(n_err - b_err), 64'd1);
    chk("t4_len", 64'(pin_len), 64'd8);
    chk("t4_digits", 64'(pin_digits), 64'h1234_5678);
    pin_ready = 1'b1;
    press(4'hF);
    chk("t4_valid", 64'(pin_valid), 64'd1);
    chk("t4_pin", 64'(pin_digits), 64'h1234_5678);
    tick();
    pin_ready = 1'b0;

    // ---------------- 5: inactivity timeout ----------------
    snap();
    press(4'h3);
    repeat (TOC - 1) tick();
    chk("t5_pre_active", 64'(entry_active), 64'd1);
    chk("t5_pre_to", 64'(n_to - b_to), 64'd0);
    tick();
    chk("t5_to_active", 64'(entry_active), 64'd0);
    chk("t5_to_digits", 64'(pin_digits), 64'hFFFF_FFFF);
    tick();
    chk("t5_to_pulse", 64'(n_to - b_to), 64'd1);
    // key lands exactly on the expiry cycle: key wins
    snap();
    press(4'h3);
    repeat (TOC - 1) tick();
    press(4'h7);
    tick();
    chk("t5b_no_to", 64'(n_to - b_to), 64'd0);
    chk("t5b_digits", 64'(pin_digits), 64'hFFFF_FF37);
    chk("t5b_active", 64'(entry_active), 64'd1);
    press(4'hC);
    chk("t5b_clear", 64'(pin_len), 64'd0);

    // ---------------- enable low aborts entry silently ----------------
    press(4'h1);
    press(4'h2);
    snap();
    enable = 1'b0;
    tick();
    chk("en_len", 64'(pin_len), 64'd0);
    chk("en_active", 64'(entry_active), 64'd0);
    press(4'h5);
    chk("en_ignored", 64'(pin_len), 64'd0);
    chk("en_no_pulses", 64'(n_ack - b_ack + n_err - b_err + n_to - b_to), 64'd0);
    enable = 1'b1;

    // ---------------- 6: held PIN, dropped keys, async reset ----------------
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    press(4'hF);
    snap();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) press(4'(i)); else tick();
    end
    enable = 1'b1;
    chk("t6_held_valid", 64'(pin_valid), 64'd1);
    chk("t6_held_digits", 64'(pin_digits), 64'hFFFF_1234);
    chk("t6_held_len", 64'(pin_len), 64'd4);
    chk("t6_no_ack", 64'(n_ack - b_ack), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(pin_valid), 64'd0);
    chk("t6_rst_digits", 64'(pin_digits), 64'hFFFF_FFFF);
    chk("t6_rst_len", 64'(pin_len), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_post_idle", 64'(entry_active), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
